// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer sizing, read-mode encodings and parameter
// legality checks used by every FIFO variant (single- and dual-clock).
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // One extra pointer bit distinguishes full from empty when addresses match.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit depth_legal(input int addr_width);
        return (addr_width >= 2) && (addr_width <= 12);
    endfunction

    function automatic bit thresh_legal(input int addr_width, input int afull, input int aempty);
        int depth;
        depth = 1 << addr_width;
        return (afull >= 1) && (afull <= depth - 1) && (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bus of the single-clock FIFO. master = the datapath that
// drives writes, reads and flush; slave = the FIFO.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  flush;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, w_en, w_data, r_en,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, w_en, w_data, r_en,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one
// combinational read port. Contents are never reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary wrap-bit pointers, registered flags and
// occupancy, sticky error flags, flush, and standard or first-word-fall-through read.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input logic clk,
    input logic rst_n,
    sync_fifo_ctrl_if.slave bus
);
    localparam int         PW   = ptr_width(ADDR_WIDTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (!depth_legal(ADDR_WIDTH) || !thresh_legal(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_param
        $error("sync_fifo_ctrl: illegal ADDR_WIDTH or threshold parameters");
    end

    logic [PW-1:0] w_ptr, r_ptr, w_ptr_nxt, r_ptr_nxt, cnt_nxt, cnt_q;
    logic          full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
    logic          wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Acceptance uses the flags registered at the start of the cycle.
    assign wr_acc    = bus.w_en && !full_q  && !bus.flush;
    assign rd_acc    = bus.r_en && !empty_q && !bus.flush;
    assign w_ptr_nxt = w_ptr + PW'(wr_acc);
    assign r_ptr_nxt = r_ptr + PW'(rd_acc);
    assign cnt_nxt   = w_ptr_nxt - r_ptr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (bus.flush) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            w_ptr    <= w_ptr_nxt;
            r_ptr    <= r_ptr_nxt;
            cnt_q    <= cnt_nxt;
            full_q   <= (w_ptr_nxt[ADDR_WIDTH-1:0] == r_ptr_nxt[ADDR_WIDTH-1:0]) &&
                        (w_ptr_nxt[ADDR_WIDTH] != r_ptr_nxt[ADDR_WIDTH]);
            empty_q  <= (w_ptr_nxt == r_ptr_nxt);
            afull_q  <= (cnt_nxt >= PW'(AFULL_THRESH));
            aempty_q <= (cnt_nxt <= PW'(AEMPTY_THRESH));
            ovf_q    <= ovf_q | (bus.w_en && full_q);
            unf_q    <= unf_q | (bus.r_en && empty_q);
        end
    end

    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (w_ptr[ADDR_WIDTH-1:0]),
        .wdata (bus.w_data),
        .raddr (r_ptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    if (MODE == FIFO_STD) begin : g_std
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) rdata_q <= mem_rdata;
            end
        end

        assign bus.r_data  = rdata_q;
        assign bus.r_valid = rvalid_q;
    end else begin : g_fwft
        // Gate with empty so stale memory never shows while nothing is queued.
        assign bus.r_data  = empty_q ? '0 : mem_rdata;
        assign bus.r_valid = !empty_q;
    end

    assign bus.count        = cnt_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one standard-read and one FWFT instance,
// scoreboard queue of expected read words.
module tb_sync_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) s();
    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) f();

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(0))
        u_std (.clk(clk), .rst_n(rst_n), .bus(s));
    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(f));

    int checks = 0;
    int fails  = 0;
    logic [7:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    // Pop the std FIFO once and compare against the scoreboard head.
    task automatic pop_chk(input string tag);
        logic [7:0] e;
        s.r_en = 1'b1;
        tick();
        s.r_en = 1'b0;
        e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        chk({tag, "_rv"}, 32'(s.r_valid), 32'd1);
        chk({tag, "_rd"}, 32'(s.r_data), 32'(e));
    endtask

    task automatic push(input logic [7:0] d);
        s.w_en   = 1'b1;
        s.w_data = d;
        tick();
        s.w_en   = 1'b0;
        sb.push_back(d);
    endtask

    initial begin
        s.flush = 0; s.w_en = 0; s.w_data = 0; s.r_en = 0;
        f.flush = 0; f.w_en = 0; f.w_data = 0; f.r_en = 0;
        tick();
        do_reset();

        chk("rst_count", 32'(s.count), 0);
        chk("rst_empty", 32'(s.empty), 1);
        chk("rst_aempty", 32'(s.almost_empty), 1);
        chk("rst_full", 32'(s.full), 0);
        chk("rst_afull", 32'(s.almost_full), 0);
        chk("rst_ovf", 32'(s.overflow), 0);
        chk("rst_unf", 32'(s.underflow), 0);
        chk("rst_rvalid", 32'(s.r_valid), 0);
        chk("rst_rdata", 32'(s.r_data), 0);
        chk("rst_f_rvalid", 32'(f.r_valid), 0);
        chk("rst_f_rdata", 32'(f.r_data), 0);

        // Fill to full, then one dropped write.
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
            chk("fill_count", 32'(s.count), 32'(i));
            chk("fill_afull", 32'(s.almost_full), 32'(i >= 6));
            chk("fill_aempty", 32'(s.almost_empty), 32'(i <= 1));
        end
        chk("fill_full", 32'(s.full), 1);
        s.w_en = 1'b1; s.w_data = 8'hFF;
        tick();
        s.w_en = 1'b0;
        chk("ovf_set", 32'(s.overflow), 1);
        chk("ovf_count", 32'(s.count), 8);

        // Drain with one-cycle read latency, then read while empty.
        for (int i = 0; i < 8; i++) pop_chk("drain");
        chk("drain_empty", 32'(s.empty), 1);
        chk("drain_unf0", 32'(s.underflow), 0);
        s.r_en = 1'b1;
        tick();
        s.r_en = 1'b0;
        chk("unf_set", 32'(s.underflow), 1);
        chk("unf_rvalid", 32'(s.r_valid), 0);

        // Steady-state streaming at count=4; pointers wrap repeatedly.
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        chk("stream_pre", 32'(s.count), 4);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] e;
            s.w_en = 1'b1; s.r_en = 1'b1; s.w_data = 8'h20 + 8'(i);
            tick();
            sb.push_back(8'h20 + 8'(i));
            e = sb.pop_front();
            chk("stream_count", 32'(s.count), 4);
            chk("stream_flags", {30'd0, s.full, s.empty}, 0);
            chk("stream_rv", 32'(s.r_valid), 1);
            chk("stream_rd", 32'(s.r_data), 32'(e));
        end
        s.w_en = 1'b0; s.r_en = 1'b0;
        for (int i = 0; i < 4; i++) pop_chk("stream_tail");
        chk("stream_empty", 32'(s.empty), 1);

        // Flush at count=5 with overflow set and a concurrent write.
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        s.w_en = 1'b1; s.w_data = 8'hEE;
        tick();
        s.w_en = 1'b0;
        for (int i = 0; i < 3; i++) pop_chk("pre_flush");
        chk("pre_flush_count", 32'(s.count), 5);
        s.flush = 1'b1; s.w_en = 1'b1; s.w_data = 8'h99;
        tick();
        s.flush = 1'b0; s.w_en = 1'b0;
        sb.delete();
        chk("flush_count", 32'(s.count), 0);
        chk("flush_empty", 32'(s.empty), 1);
        chk("flush_ovf_kept", 32'(s.overflow), 1);
        chk("flush_rvalid", 32'(s.r_valid), 0);
        tick();
        chk("flush_no_store", 32'(s.count), 0);
        push(8'h42);
        pop_chk("post_flush");
        do_reset();
        chk("rst_ovf_clr", 32'(s.overflow), 0);

        // Full with simultaneous w_en/r_en: read wins, write rejected.
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        s.w_en = 1'b1; s.r_en = 1'b1; s.w_data = 8'hEE;
        tick();
        s.w_en = 1'b0; s.r_en = 1'b0;
        chk("fullrw_count", 32'(s.count), 7);
        chk("fullrw_ovf", 32'(s.overflow), 1);
        chk("fullrw_rd", 32'(s.r_data), 32'(sb.pop_front()));
        for (int i = 0; i < 7; i++) pop_chk("fullrw_drain");

        // Empty with simultaneous w_en/r_en: write wins, read rejected.
        s.w_en = 1'b1; s.r_en = 1'b1; s.w_data = 8'h77;
        tick();
        s.w_en = 1'b0; s.r_en = 1'b0;
        sb.push_back(8'h77);
        chk("emptyrw_count", 32'(s.count), 1);
        chk("emptyrw_unf", 32'(s.underflow), 1);
        chk("emptyrw_rvalid", 32'(s.r_valid), 0);
        pop_chk("emptyrw_pop");

        // FWFT instance: head word presented without r_en.
        f.w_en = 1'b1; f.w_data = 8'hA5;
        tick();
        f.w_en = 1'b0;
        chk("fwft_rv", 32'(f.r_valid), 1);
        chk("fwft_rd", 32'(f.r_data), 32'hA5);
        chk("fwft_empty", 32'(f.empty), 0);
        f.w_en = 1'b1; f.w_data = 8'h11;
        tick();
        f.w_en = 1'b0;
        chk("fwft_head_hold", 32'(f.r_data), 32'hA5);
        f.r_en = 1'b1;
        tick();
        chk("fwft_next", 32'(f.r_data), 32'h11);
        tick();
        f.r_en = 1'b0;
        chk("fwft_empty_after", 32'(f.empty), 1);
        chk("fwft_rv_after", 32'(f.r_valid), 0);
        chk("fwft_unf", 32'(f.underflow), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO that supersedes the pointer/flag logic used on each side of the dual-clock FIFO wherever producer and consumer share a clock.
- Adds over the dual-clock version: programmable almost-full/almost-empty thresholds, an occupancy count, a selectable first-word-fall-through (FWFT) mode, synchronous flush, and sticky overflow/underflow error flags.
- Sits between datapath stages as an elastic buffer.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 2..12
AFULL_THRESH, 6, almost_full asserts when count >= AFULL_THRESH; range 1..DEPTH-1
AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH; range 0..DEPTH-1
FWFT, 0, 0 = standard read (data one cycle after r_en); 1 = head word presented while not empty

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
flush  in  1  synchronous clear of contents; pointers only, memory untouched
w_en  in  1  write request
w_data  in  DATA_WIDTH  write data
r_en  in  1  read request (pop)
r_data  out  DATA_WIDTH  read data
r_valid  out  1  r_data holds a valid popped/head word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - w_ptr = r_ptr = 0, count = 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - overflow=0, underflow=0, r_valid=0, r_data=0.
- Pointers: ADDR_WIDTH+1 bits, binary. The low ADDR_WIDTH bits address memory; the MSB is the wrap bit.
  - full = (addr bits equal) && (MSBs differ).
  - empty = pointers equal.
  - Pointers wrap modulo 2**(ADDR_WIDTH+1).
- wr_acc = w_en && !full; rd_acc = r_en && !empty. Both use flags registered at the start of the cycle.
  - Write while full is dropped: memory and pointers unchanged, overflow set.
  - Read while empty is dropped: underflow set.
- Simultaneous wr_acc and rd_acc: count unchanged, both pointers advance.
  - Full + w_en + r_en: read accepted, write rejected (overflow set).
  - Empty + w_en + r_en: write accepted, read rejected (underflow set).
- count, full, empty, almost_* are registered and update in the cycle after the accepting edge.
- FWFT=0:
  - On rd_acc, r_data <= mem[r_ptr] and r_valid <= 1 at the same edge.
  - With no rd_acc, r_valid <= 0 and r_data holds its value.
  - Read latency: 1 cycle.
- FWFT=1:
  - r_data = mem[r_ptr] combinationally; r_valid = !empty.
  - r_en pops the currently presented word.
  - Written data appears on r_data the cycle after wr_acc (empty deasserts then).
- Write-to-read latency (empty deasserted): 1 cycle in both modes.
- flush (with rst_n=1):
  - Next edge: pointers=0, count=0, empty=1, r_valid=0.
  - Any concurrent w_en/r_en is ignored.
  - overflow/underflow are NOT cleared.
  - rst_n has priority over flush.
- Sticky flags clear only on reset.
- Memory write: synchronous, on wr_acc, mem[w_ptr[ADDR_WIDTH-1:0]] <= w_data. No reset of memory contents.

Decomposition:
- Shared package fifo_pkg holds:
  - pointer-width helper constant/function (ADDR_WIDTH+1)
  - the FWFT mode encodings (FIFO_STD=0, FIFO_FWFT=1)
  - threshold-legality checks used by all FIFO variants
- Sub-module fifo_mem: DEPTH x DATA_WIDTH register array with one synchronous write port and one combinational read port. The controller instantiates it and adds the output register when FWFT=0.
- The same fifo_mem is reused by the dual-clock FIFO.

Test Plan:
- Defaults (DEPTH=8). Reset, then write 0x01..0x08 back-to-back -> count steps 1..8; almost_full at count=6; full=1 after 8th write; 9th write (0xFF) dropped, overflow=1, count stays 8.
- Full FIFO, FWFT=0. Pop 8 times -> r_data 0x01..0x08, each one cycle after r_en with r_valid=1; empty=1 after last pop; extra r_en sets underflow=1, r_valid=0.
- Count=4, w_en and r_en every cycle for 20 cycles -> count holds 4, output order is strict FIFO, pointers wrap past 15 -> 0 without flag glitches.
- FWFT=1, empty. Write 0xA5 -> next cycle r_valid=1, r_data=0xA5 with no r_en. Pop -> empty=1, r_valid=0 next cycle.
- Count=5, overflow=1. Assert flush with w_en=1 -> next cycle count=0, empty=1, overflow still 1, written word not stored. Assert rst_n=0 for one edge -> overflow=0.
- Full FIFO, w_en=r_en=1 -> one word popped, write rejected, count=7, overflow=1. Empty FIFO, w_en=r_en=1 -> count=1, underflow=1.
